// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcode values, FSM state encoding
// and bit positions of the {N,Z,C,V} flags.
package exec_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_CMP  = 4'h9;
    localparam logic [3:0] OP_PASS = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/exec_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, low WIDTH
// bits of the product. o_done/o_product are valid in the last iteration cycle.
module exec_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_sum;

    assign w_partial = r_mplier[0] ? r_mcand : '0;
    assign w_sum     = r_acc + w_partial;
    // The final accumulation is offered combinationally so the top can latch
    // it on the WIDTH-th edge after start.
    assign o_done    = r_busy && (r_cnt == LAST);
    assign o_product = w_sum;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (r_busy) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU with registered result/flags/err and a
// valid/ready output. Defining EXECUTE_STAGE_MUL_EN adds a multi-cycle multiply.
module execute_stage
    import exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] source1,
    input  logic [WIDTH-1:0] source2,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err,
    output state_t           o_dbg_state
);

    localparam int M = WIDTH - 1;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_err;

    logic             w_accept;
    logic             w_is_mul;
    logic [3:0]       w_amt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH:0]   w_sra;
    logic [WIDTH-1:0] w_alu_result;
    logic [WIDTH-1:0] w_nz_src;
    logic             w_c;
    logic             w_v;
    logic             w_illegal;
    logic [3:0]       w_alu_flags;

    assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign flags       = r_flags;
    assign err         = r_err;
    assign o_dbg_state = r_state;

    // Shifts carry one guard bit so the last bit shifted out lands in C.
    assign w_amt  = source2[3:0];
    assign w_sum  = {1'b0, source1} + {1'b0, source2};
    assign w_diff = {1'b0, source1} - {1'b0, source2};
    assign w_shl  = {1'b0, source1} << w_amt;
    assign w_shr  = {source1, 1'b0} >> w_amt;
    assign w_sra  = $signed({source1, 1'b0}) >>> w_amt;

    always_comb begin
        w_alu_result = '0;
        w_c          = 1'b0;
        w_v          = 1'b0;
        w_illegal    = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_alu_result = w_sum[M:0];
                w_c = w_sum[WIDTH];
                w_v = (source1[M] == source2[M]) && (w_sum[M] != source1[M]);
            end
            OP_SUB, OP_CMP: begin
                // SUB reports "no borrow" in C; CMP keeps s1 but flags the difference.
                w_alu_result = (opcode == OP_CMP) ? source1 : w_diff[M:0];
                w_c = ~w_diff[WIDTH];
                w_v = (source1[M] != source2[M]) && (w_diff[M] != source1[M]);
            end
            OP_AND:  w_alu_result = source1 & source2;
            OP_OR:   w_alu_result = source1 | source2;
            OP_XOR:  w_alu_result = source1 ^ source2;
            OP_NOT:  w_alu_result = ~source1;
            OP_SHL: begin
                w_alu_result = w_shl[M:0];
                w_c = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_result = w_shr[WIDTH:1];
                w_c = w_shr[0];
            end
            OP_SRA: begin
                w_alu_result = w_sra[WIDTH:1];
                w_c = w_sra[0];
            end
            OP_PASS: w_alu_result = source2;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_nz_src = (opcode == OP_CMP) ? w_diff[M:0] : w_alu_result;

    always_comb begin
        w_alu_flags         = '0;
        w_alu_flags[FLAG_N] = w_nz_src[M];
        w_alu_flags[FLAG_Z] = (w_nz_src == '0);
        w_alu_flags[FLAG_C] = w_c;
        w_alu_flags[FLAG_V] = w_v;
    end

`ifdef EXECUTE_STAGE_MUL_EN
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    assign w_is_mul = (opcode == OP_MUL);

    exec_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock     (clock),
        .resetb    (resetb),
        .i_start   (w_accept && w_is_mul),
        .i_a       (source1),
        .i_b       (source2),
        .o_done    (w_mul_done),
        .o_product (w_mul_product)
    );
`else
    assign w_is_mul = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state     <= ST_MUL;
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_out_valid <= 1'b1;
                        r_result    <= w_illegal ? '0 : w_alu_result;
                        r_flags     <= w_illegal ? 4'b0 : w_alu_flags;
                        r_err       <= w_illegal;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
`ifdef EXECUTE_STAGE_MUL_EN
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state             <= ST_HOLD;
                        r_out_valid         <= 1'b1;
                        r_result            <= w_mul_product;
                        r_flags             <= '0;
                        r_flags[FLAG_N]     <= w_mul_product[M];
                        r_flags[FLAG_Z]     <= (w_mul_product == '0);
                        r_err               <= 1'b0;
                    end
                end
`endif
                ST_HOLD: begin
                    if (!r_out_valid || out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
